keypad_scanner: RTL

Scans a 4x4 matrix keypad for the parking-meter front panel and turns key closures into clean, single-cycle key events. Drives the keypad columns the same way the display driver drives its digit anodes: one active-low strobe at a time, multiplexed. Runs on the raw board clock with an internal dwell counter. Downstream logic in the top level decodes the 4-bit key code into the meter's deposit and reset requests, replacing the discrete push-buttons.

---
 rtl/keypad_scanner.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes one active-low column at a time, samples the rows,
// and debounces whole-scan results into single-cycle key events for the parking meter.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held,
    output logic       multi
);

    localparam int             DW         = $clog2(SCAN_DIV);
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0]     DEB        = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, CAND, PRESSED, REL} state_t;

    logic [3:0]    row_meta, row_sync;
    logic [DW-1:0] dwell_cnt;
    logic [1:0]    col_idx;
    logic [11:0]   snapshot;
    logic          sample, eval;
    logic [15:0]   scan_bits;
    logic [4:0]    n_keys;
    logic [3:0]    hit_code;
    logic          single, none;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [3:0] cand, cand_n;
    logic [3:0] key_n;
    logic       key_valid_n, key_held_n, multi_n;

    assign sample    = (dwell_cnt == DWELL_LAST);
    assign eval      = sample && (col_idx == 2'd3);
    assign scan_bits = {~row_sync, snapshot};
    assign single    = (n_keys == 5'd1);
    assign none      = (n_keys == 5'd0);

    always_comb begin
        col = ~(4'b0001 << col_idx);
    end

    // Column 3 is never stored: it is classified straight from the synchronized rows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta  <= 4'hF;
            row_sync  <= 4'hF;
            dwell_cnt <= '0;
            col_idx   <= 2'd0;
            snapshot  <= '0;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
            if (sample) begin
                dwell_cnt <= '0;
                col_idx   <= col_idx + 2'd1;
                case (col_idx)
                    2'd0:    snapshot[3:0]  <= ~row_sync;
                    2'd1:    snapshot[7:4]  <= ~row_sync;
                    2'd2:    snapshot[11:8] <= ~row_sync;
                    default: ;
                endcase
            end else begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        n_keys   = '0;
        hit_code = '0;
        for (int i = 0; i < 16; i++) begin
            if (scan_bits[i]) begin
                n_keys   = n_keys + 5'd1;
                hit_code = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= '0;
            key       <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            multi     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cand      <= cand_n;
            key       <= key_n;
            key_valid <= key_valid_n;
            key_held  <= key_held_n;
            multi     <= multi_n;
        end
    end

    // A multi-key scan looks like "nothing" to press acceptance but "something" to release.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        cand_n      = cand;
        key_n       = key;
        key_valid_n = 1'b0;
        key_held_n  = key_held;
        multi_n     = multi;
        if (eval) begin
            multi_n = (n_keys >= 5'd2);
            case (state)
                IDLE: begin
                    if (single) begin
                        if (DEB == 4'd1) begin
                            state_n     = PRESSED;
                            key_n       = hit_code;
                            key_valid_n = 1'b1;
                            key_held_n  = 1'b1;
                        end else begin
                            state_n = CAND;
                            cand_n  = hit_code;
                            cnt_n   = 4'd1;
                        end
                    end
                end
                CAND: begin
                    if (single && hit_code == cand) begin
                        if (cnt + 4'd1 == DEB) begin
                            state_n     = PRESSED;
                            key_n       = cand;
                            key_valid_n = 1'b1;
                            key_held_n  = 1'b1;
                        end else begin
                            cnt_n = cnt + 4'd1;
                        end
                    end else if (single) begin
                        cand_n = hit_code;
                        cnt_n  = 4'd1;
                    end else begin
                        state_n = IDLE;
                    end
                end
                PRESSED: begin
                    if (none) begin
                        if (DEB == 4'd1) begin
                            state_n    = IDLE;
                            key_held_n = 1'b0;
                        end else begin
                            state_n = REL;
                            cnt_n   = 4'd1;
                        end
                    end
                end
                REL: begin
                    if (none) begin
                        if (cnt + 4'd1 == DEB) begin
                            state_n    = IDLE;
                            key_held_n = 1'b0;
                        end else begin
                            cnt_n = cnt + 4'd1;
                        end
                    end else begin
                        state_n = PRESSED;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule
